usrt_ctrl: RTL and testbench

// APB-side controller that sequences the USRT datapath: decodes APB transfers, inserts wait states, and runs TX and RX frame FSMs.

---
 rtl/usrt_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_usrt_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usrt_ctrl.sv
// USRT controller: APB slave with wait states, 11-bit serial TX/RX frames (start=1, 8 data LSB-first, even parity, stop=0).
// Latency: uTxd starts one cycle after a DATA write is accepted; rx_valid/rx_err update on the STOP sample cycle.
// Backpressure: a DATA write while a frame is in flight holds pReady low until the last STOP cycle.
module usrt_ctrl #(
    parameter int DIV = 80
) (
    input  logic       pClk,
    input  logic       uRst,
    input  logic       pSelect,
    input  logic       pEnable,
    input  logic       pWrite,
    input  logic [1:0] pAddress,
    input  logic [7:0] pWData,
    output logic [7:0] pRData,
    output logic       pReady,
    output logic       uTxd,
    input  logic       uRxd,
    output logic       tx_busy,
    output logic       rx_valid
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] BIT_MID  = CW'(DIV / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} frame_state_t;

    frame_state_t tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_bit, tx_bit_nxt;
    logic [7:0]    tx_data, tx_data_nxt;
    logic          txd_nxt;

    frame_state_t rx_state, rx_state_nxt;
    logic [CW-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]    rx_bit, rx_bit_nxt;
    logic [7:0]    rx_shift, rx_shift_nxt;
    logic          rx_par, rx_par_nxt;
    logic [7:0]    rx_data, rx_data_nxt;
    logic          rx_valid_nxt;
    logic          rx_err, rx_err_nxt;

    logic access, wr_data_req, rd_data_done, rd_stat_done;
    logic tx_tick, tx_free, tx_accept;
    logic stop_sample, frame_good;

    assign access       = pSelect & pEnable;
    assign wr_data_req  = access & pWrite & (pAddress == 2'd0);
    assign rd_data_done = access & ~pWrite & (pAddress == 2'd0);
    assign rd_stat_done = access & ~pWrite & (pAddress == 2'd1);

    // TX counts as free on its last STOP cycle so a held write chains frames with no gap.
    assign tx_tick   = (tx_cnt == BIT_LAST);
    assign tx_free   = (tx_state == IDLE) || ((tx_state == STOP) && tx_tick);
    assign tx_accept = wr_data_req & tx_free;
    assign pReady    = ~(wr_data_req & ~tx_free);
    assign tx_busy   = (tx_state != IDLE);

    always_comb begin
        pRData = 8'h00;
        if (pSelect) begin
            case (pAddress)
                2'd0:    pRData = rx_data;
                2'd1:    pRData = {5'b0, rx_err, rx_valid, tx_busy};
                default: pRData = 8'h00;
            endcase
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_tick ? '0 : tx_cnt + 1'b1;
        tx_bit_nxt   = tx_bit;
        tx_data_nxt  = tx_data;
        txd_nxt      = uTxd;
        case (tx_state)
            IDLE: begin
                tx_cnt_nxt = '0;
                if (tx_accept) begin
                    tx_state_nxt = START;
                    tx_data_nxt  = pWData;
                    txd_nxt      = 1'b1;
                end
            end
            START: begin
                if (tx_tick) begin
                    tx_state_nxt = DATA;
                    tx_bit_nxt   = 3'd0;
                    txd_nxt      = tx_data[0];
                end
            end
            DATA: begin
                if (tx_tick) begin
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = PARITY;
                        txd_nxt      = ^tx_data;
                    end else begin
                        tx_bit_nxt = tx_bit + 3'd1;
                        txd_nxt    = tx_data[tx_bit + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (tx_tick) begin
                    tx_state_nxt = STOP;
                    txd_nxt      = 1'b0;
                end
            end
            STOP: begin
                if (tx_tick) begin
                    if (tx_accept) begin
                        tx_state_nxt = START;
                        tx_data_nxt  = pWData;
                        txd_nxt      = 1'b1;
                    end else begin
                        tx_state_nxt = IDLE;
                        txd_nxt      = 1'b0;
                    end
                end
            end
            default: begin
                tx_state_nxt = IDLE;
                txd_nxt      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pClk) begin
        if (uRst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_data  <= 8'h00;
            uTxd     <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_data  <= tx_data_nxt;
            uTxd     <= txd_nxt;
        end
    end

    assign frame_good = (rx_par == ^rx_shift) & ~uRxd;

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt + 1'b1;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_par_nxt   = rx_par;
        stop_sample  = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_cnt_nxt = '0;
                if (uRxd) rx_state_nxt = START;
            end
            START: begin
                if (rx_cnt == BIT_MID) begin
                    rx_cnt_nxt   = '0;
                    rx_bit_nxt   = 3'd0;
                    rx_state_nxt = uRxd ? DATA : IDLE;
                end
            end
            DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {uRxd, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_nxt = PARITY;
                    else                rx_bit_nxt   = rx_bit + 3'd1;
                end
            end
            PARITY: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_par_nxt   = uRxd;
                    rx_state_nxt = STOP;
                end
            end
            STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    stop_sample  = 1'b1;
                    rx_state_nxt = IDLE;
                end
            end
            default: begin
                rx_cnt_nxt   = '0;
                rx_state_nxt = IDLE;
            end
        endcase
    end

    // A DATA read completing on the STOP sample frees the holding register for the new byte.
    always_comb begin
        rx_data_nxt  = rx_data;
        rx_valid_nxt = rx_valid;
        rx_err_nxt   = rx_err;
        if (rd_data_done) rx_valid_nxt = 1'b0;
        if (rd_stat_done) rx_err_nxt   = 1'b0;
        if (stop_sample) begin
            if (!frame_good) begin
                rx_err_nxt = 1'b1;
            end else if (!rx_valid || rd_data_done) begin
                rx_data_nxt  = rx_shift;
                rx_valid_nxt = 1'b1;
            end else begin
                rx_err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge pClk) begin
        if (uRst) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_par   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
            rx_par   <= rx_par_nxt;
            rx_data  <= rx_data_nxt;
            rx_valid <= rx_valid_nxt;
            rx_err   <= rx_err_nxt;
        end
    end

endmodule

// File: tb/tb_usrt_ctrl.sv
// Directed bench for usrt_ctrl at DIV=4: APB access, TX framing/chaining, RX flags, reset.
module tb_usrt_ctrl;

    logic       pClk = 1'b0;
    logic       uRst;
    logic       pSelect, pEnable, pWrite;
    logic [1:0] pAddress;
    logic [7:0] pWData;
    logic [7:0] pRData;
    logic       pReady;
    logic       uTxd;
    logic       uRxd;
    logic       tx_busy;
    logic       rx_valid;

    int checks = 0;
    int errors = 0;

    always #5 pClk = ~pClk;

    usrt_ctrl #(.DIV(4)) dut (
        .pClk     (pClk),
        .uRst     (uRst),
        .pSelect  (pSelect),
        .pEnable  (pEnable),
        .pWrite   (pWrite),
        .pAddress (pAddress),
        .pWData   (pWData),
        .pRData   (pRData),
        .pReady   (pReady),
        .uTxd     (uTxd),
        .uRxd     (uRxd),
        .tx_busy  (tx_busy),
        .rx_valid (rx_valid)
    );

    task automatic apb_write(input logic [1:0] a, input logic [7:0] d, output int waits);
        @(negedge pClk);
        pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddress = a; pWData = d;
        @(negedge pClk);
        pEnable = 1'b1;
        waits = 0;
        #1;
        while (!pReady && waits < 200) begin
            @(negedge pClk);
            #1;
            waits++;
        end
        if (!pReady) begin
            errors++;
            $display("FAIL write_timeout: pReady=%b after %0d cycles, required 1", pReady, waits);
        end
        @(negedge pClk);
        pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    endtask

    task automatic apb_read(input logic [1:0] a, output logic [7:0] d, output logic rdy);
        @(negedge pClk);
        pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b0; pAddress = a;
        @(negedge pClk);
        pEnable = 1'b1;
        #1;
        d   = pRData;
        rdy = pReady;
        @(negedge pClk);
        pSelect = 1'b0; pEnable = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stopb);
        @(negedge pClk);
        uRxd = 1'b1;
        repeat (4) @(negedge pClk);
        for (int i = 0; i < 8; i++) begin
            uRxd = d[i];
            repeat (4) @(negedge pClk);
        end
        uRxd = par;
        repeat (4) @(negedge pClk);
        uRxd = stopb;
        repeat (4) @(negedge pClk);
        uRxd = 1'b0;
    endtask

    task automatic test_reset();
        uRst = 1'b1;
        pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0; pAddress = 2'd0; pWData = 8'h00; uRxd = 1'b0;
        repeat (3) @(negedge pClk);
        checks++;
        if ({uTxd, tx_busy, rx_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: uTxd/tx_busy/rx_valid=%b required 000", {uTxd, tx_busy, rx_valid});
        end
        pSelect = 1'b1; pAddress = 2'd1;
        #1;
        checks++;
        if (pRData !== 8'h00) begin
            errors++;
            $display("FAIL reset_status: got %h required 00", pRData);
        end
        pAddress = 2'd0;
        #1;
        checks++;
        if (pRData !== 8'h00 || pReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_data: pRData=%h pReady=%b required 00/1", pRData, pReady);
        end
        @(negedge pClk);
        pSelect = 1'b0;
        uRst = 1'b0;
        @(negedge pClk);
    endtask

    task automatic test_tx_frame(input logic [7:0] d, input logic [10:0] exp);
        int w;
        apb_write(2'd0, d, w);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL tx_idle_wait: byte %h waited %0d required 0", d, w);
        end
        for (int i = 0; i < 44; i++) begin
            checks++;
            if ({tx_busy, uTxd} !== {1'b1, exp[i/4]}) begin
                errors++;
                $display("FAIL tx_bit: byte %h cycle %0d busy/txd=%b required %b", d, i, {tx_busy, uTxd}, {1'b1, exp[i/4]});
            end
            @(negedge pClk);
        end
        checks++;
        if ({tx_busy, uTxd} !== 2'b00) begin
            errors++;
            $display("FAIL tx_end: byte %h busy/txd=%b required 00", d, {tx_busy, uTxd});
        end
    endtask

    task automatic test_ignored_writes();
        int w;
        apb_write(2'd1, 8'hFF, w);
        apb_write(2'd3, 8'hFF, w);
        checks++;
        if (w !== 0 || tx_busy !== 1'b0 || uTxd !== 1'b0) begin
            errors++;
            $display("FAIL ignored_write: waits=%0d busy=%b txd=%b required 0/0/0", w, tx_busy, uTxd);
        end
        pSelect = 1'b0; pEnable = 1'b1; pWrite = 1'b1; pAddress = 2'd0; pWData = 8'hFF;
        @(negedge pClk);
        pEnable = 1'b0; pWrite = 1'b0;
        @(negedge pClk);
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL enable_no_select: tx_busy=%b required 0", tx_busy);
        end
    endtask

    task automatic test_back_to_back();
        int w1, w2;
        logic [10:0] f1, f2;
        f1 = 11'b01000000011;
        f2 = 11'b01000000101;
        apb_write(2'd0, 8'h01, w1);
        fork
            apb_write(2'd0, 8'h02, w2);
            begin
                for (int i = 0; i <= 88; i++) begin
                    logic expb;
                    checks++;
                    if (i < 88) begin
                        expb = (i < 44) ? f1[i/4] : f2[(i-44)/4];
                        if ({tx_busy, uTxd} !== {1'b1, expb}) begin
                            errors++;
                            $display("FAIL b2b_bit: cycle %0d busy/txd=%b required %b", i, {tx_busy, uTxd}, {1'b1, expb});
                        end
                        @(negedge pClk);
                    end else if ({tx_busy, uTxd} !== 2'b00) begin
                        errors++;
                        $display("FAIL b2b_end: busy/txd=%b required 00", {tx_busy, uTxd});
                    end
                end
            end
        join
        checks++;
        if (w1 !== 0 || w2 !== 41) begin
            errors++;
            $display("FAIL b2b_waits: first=%0d second=%0d required 0/41", w1, w2);
        end
    endtask

    task automatic test_rx_good();
        logic [7:0] d;
        logic r;
        send_frame(8'h3C, 1'b0, 1'b0);
        checks++;
        if (rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL rx_good_valid: rx_valid=%b required 1", rx_valid);
        end
        apb_read(2'd1, d, r);
        checks++;
        if (d !== 8'h02 || r !== 1'b1) begin
            errors++;
            $display("FAIL rx_good_status: got %h ready %b required 02/1", d, r);
        end
        apb_read(2'd0, d, r);
        checks++;
        if (d !== 8'h3C) begin
            errors++;
            $display("FAIL rx_good_data: got %h required 3c", d);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_good_clear: rx_valid=%b required 0", rx_valid);
        end
    endtask

    task automatic test_rx_parity();
        logic [7:0] d;
        logic r;
        send_frame(8'h3C, 1'b1, 1'b0);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_par_valid: rx_valid=%b required 0", rx_valid);
        end
        apb_read(2'd1, d, r);
        checks++;
        if (d !== 8'h04) begin
            errors++;
            $display("FAIL rx_par_status: got %h required 04", d);
        end
        apb_read(2'd1, d, r);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL rx_par_clear: got %h required 00", d);
        end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] d;
        logic r;
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        apb_read(2'd0, d, r);
        checks++;
        if (d !== 8'h11) begin
            errors++;
            $display("FAIL overrun_data: got %h required 11", d);
        end
        apb_read(2'd1, d, r);
        checks++;
        if (d !== 8'h04) begin
            errors++;
            $display("FAIL overrun_status: got %h required 04", d);
        end
    endtask

    task automatic test_rx_read_collision();
        logic [7:0] d, d2;
        logic r;
        send_frame(8'h55, 1'b0, 1'b0);
        fork
            send_frame(8'h96, 1'b0, 1'b0);
            begin
                repeat (41) @(negedge pClk);
                apb_read(2'd0, d, r);
            end
        join
        checks++;
        if (d !== 8'h55 || rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL collide_read: data %h valid %b required 55/1", d, rx_valid);
        end
        apb_read(2'd1, d2, r);
        checks++;
        if (d2 !== 8'h02) begin
            errors++;
            $display("FAIL collide_status: got %h required 02", d2);
        end
        apb_read(2'd0, d2, r);
        checks++;
        if (d2 !== 8'h96) begin
            errors++;
            $display("FAIL collide_data: got %h required 96", d2);
        end
    endtask

    task automatic test_rx_glitch();
        logic [7:0] d;
        logic r;
        @(negedge pClk);
        uRxd = 1'b1;
        @(negedge pClk);
        uRxd = 1'b0;
        repeat (50) @(negedge pClk);
        apb_read(2'd1, d, r);
        checks++;
        if (d !== 8'h00 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch: status %h valid %b required 00/0", d, rx_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        int w;
        logic [7:0] d;
        logic r;
        apb_write(2'd0, 8'h08, w);
        apb_read(2'd1, d, r);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("FAIL midrst_status: got %h required 01", d);
        end
        repeat (14) @(negedge pClk);
        checks++;
        if ({tx_busy, uTxd} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_d3: busy/txd=%b required 11", {tx_busy, uTxd});
        end
        uRst = 1'b1;
        @(negedge pClk);
        checks++;
        if ({tx_busy, uTxd} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_clear: busy/txd=%b required 00", {tx_busy, uTxd});
        end
        uRst = 1'b0;
        test_tx_frame(8'h5A, 11'b00010110101);
    endtask

    initial begin
        test_reset();
        test_tx_frame(8'hA5, 11'b00101001011);
        test_ignored_writes();
        test_back_to_back();
        test_rx_good();
        test_rx_parity();
        test_rx_overrun();
        test_rx_read_collision();
        test_rx_glitch();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
